vdp_bus_master: RTL and testbench
=================================

Name: vdp_bus_master

Overview:
- Z80-side I/O initiator for the VDP port decoder. It turns single-byte and two-byte VDP commands into IORQ_L/RD_L/WR_L bus cycles on port 0xBE (data) or 0xBF (control).
- Uses: board bring-up, BIST, and CPU-less simulation of the VDP.
- Sits on clk_4 in front of vdp_top. It drives addr_bus_in, data_bus_in and the strobes, and samples data_bus_out.

Parameters:
- DATA_PORT, 8'hBE, I/O address of the VDP data port.
- CTRL_PORT, 8'hBF, I/O address of the VDP control port.
- STROBE_CYC, 1, cycles the strobes are held low. Legal range 1..3.
- HOLD_CYC, 2, cycles addr/data are held after the strobe. Constraint: STROBE_CYC-1+HOLD_CYC >= 2.
- RECOVER_CYC, 1, idle cycles after each byte. Must be >= 1.
- STALL_ON_BUSY, 1, when 1, data-port cycles wait while vdp_busy is high.

Ports:
- clk  in  1  system clock (clk_4 domain)
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid & cmd_ready
- cmd_op  in  3  vdp_op_t
- cmd_data  in  8  write byte, or register value for SET_REG
- cmd_arg  in  16  SET_ADDR: {code[1:0], addr[13:0]}; SET_REG: reg index in [3:0]
- rsp_valid  out  1  one-cycle pulse carrying read data
- rsp_data  out  8  read byte, valid with rsp_valid
- done  out  1  one-cycle pulse when a command completes
- vdp_busy  in  1  VDP BUSY output
- io_addr  out  8  to addr_bus_in
- io_wdata  out  8  to data_bus_in
- io_rdata  in  8  from data_bus_out
- IORQ_L, RD_L, WR_L  out  1 each  active-low strobes

Behaviour:
- Reset (rst=1 at posedge):
  - IORQ_L=RD_L=WR_L=1; io_addr=0, io_wdata=0; rsp_valid=0, rsp_data=0, done=0.
  - State IDLE. cmd_ready=0 while rst is high.
  - Reset mid-operation: the in-flight command is dropped; no rsp_valid or done pulse.
- Ops:
  - WR_DATA=0: one write of cmd_data to DATA_PORT.
  - WR_CTRL=1: one write of cmd_data to CTRL_PORT.
  - RD_DATA=2: one read from DATA_PORT.
  - RD_STAT=3: one read from CTRL_PORT.
  - SET_ADDR=4: two CTRL_PORT writes, addr[7:0] then {code, addr[13:8]}.
  - SET_REG=5: two CTRL_PORT writes, cmd_data then 8'h80 | {4'b0, reg[3:0]}.
  - Ops 6 and 7: accepted, no bus activity, done pulses in the cycle after acceptance.
- States: IDLE -> SETUP -> STROBE -> HOLD -> RECOVER -> (SETUP for the second byte | IDLE).
- SETUP (1 cycle): io_addr and io_wdata take their byte values; strobes stay high.
  - If STALL_ON_BUSY=1, the port is DATA_PORT and vdp_busy=1, remain in SETUP.
  - The busy check is made only in SETUP. BUSY rising during a cycle does not abort it.
- STROBE (STROBE_CYC cycles): IORQ_L=0, plus WR_L=0 for writes or RD_L=0 for reads.
- HOLD (HOLD_CYC cycles): strobes high; io_addr and io_wdata unchanged. For reads, rsp_data <= io_rdata at the posedge ending the last HOLD cycle.
- RECOVER (RECOVER_CYC cycles): strobes high; io_addr and io_wdata are retained.
  - rsp_valid=1 in the first RECOVER cycle of a read.
  - done=1 in the last RECOVER cycle of the last byte.
- Latency: each byte takes 1+STROBE_CYC+HOLD_CYC+RECOVER_CYC cycles (5 with defaults).
  - Command accepted at edge E: IORQ_L falls at E+2, done is high in cycle E+5.
  - Two-byte ops take 10 cycles; the second SETUP directly follows the first RECOVER.
- cmd_ready rises in the cycle after done, so the minimum gap between byte cycles of back-to-back commands is RECOVER_CYC+1.
- cmd_* inputs are registered at acceptance. Later changes on cmd_* do not affect the command in flight.

Decomposition:
- vdp_pkg holds:
  - vdp_op_t enum (3 bits);
  - VDP_DATA_PORT / VDP_CTRL_PORT constants;
  - VDP_REG_WRITE_CODE = 8'h80;
  - bus_state_t enum.
- Sub-module vdp_io_cycle is the single-byte engine (SETUP/STROBE/HOLD/RECOVER plus counters). It has handshake byte_start/byte_done and the busy gate.
- vdp_bus_master wraps it with the command register and a first/second-byte sequencer.

Test Plan:
- WR_DATA, cmd_data=0x5A -> one cycle to 0xBE: IORQ_L=WR_L=0 for exactly 1 cycle, io_wdata=0x5A stable from SETUP through RECOVER, done at E+5, RD_L stays 1.
- SET_ADDR, cmd_arg={2'b01,14'h1234} -> writes to 0xBF of 0x34 then 0x52; the decoder sees CSW_L low with MODE=1 twice; done after 10 cycles.
- RD_STAT with io_rdata=0x80 -> RD_L low 1 cycle on 0xBF; rsp_valid pulse with rsp_data=0x80; done in the same cycle (RECOVER_CYC=1).
- STALL_ON_BUSY=1, vdp_busy=1 held 20 cycles, then WR_DATA -> no strobe while busy; IORQ_L falls 1 cycle after vdp_busy drops. The same with WR_CTRL -> no stall.
- rst pulsed during STROBE of a SET_REG -> strobes high at the next edge; no done or rsp_valid; cmd_ready=1 after rst falls; the next command executes normally.
- Back-to-back WR_DATA 0x01, 0x02 with cmd_valid held -> two separate strobes with a gap >= 2 cycles; two done pulses; op 7 -> done one cycle after acceptance with no strobes.

Source files
------------

// File: rtl/vdp_pkg.sv
// Shared types and constants for the Z80-side VDP I/O bus master.
// Holds the command opcodes, the port addresses and the FSM state encodings.
package vdp_pkg;

    typedef enum logic [2:0] {
        OP_WR_DATA  = 3'd0,
        OP_WR_CTRL  = 3'd1,
        OP_RD_DATA  = 3'd2,
        OP_RD_STAT  = 3'd3,
        OP_SET_ADDR = 3'd4,
        OP_SET_REG  = 3'd5,
        OP_RSVD6    = 3'd6,
        OP_RSVD7    = 3'd7
    } vdp_op_t;

    localparam logic [7:0] VDP_DATA_PORT      = 8'hBE;
    localparam logic [7:0] VDP_CTRL_PORT      = 8'hBF;
    localparam logic [7:0] VDP_REG_WRITE_CODE = 8'h80;

    typedef enum logic [2:0] {
        BUS_IDLE,
        BUS_SETUP,
        BUS_STROBE,
        BUS_HOLD,
        BUS_RECOVER
    } bus_state_t;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_FIRST,
        SEQ_SECOND,
        SEQ_NOP,
        SEQ_NOP_DONE
    } seq_state_t;

    function automatic logic is_two_byte(input vdp_op_t op);
        return (op == OP_SET_ADDR) || (op == OP_SET_REG);
    endfunction

endpackage

// File: rtl/vdp_io_cycle.sv
// Single-byte Z80 I/O cycle engine: SETUP / STROBE / HOLD / RECOVER with
// per-phase cycle counters and an optional stall on VDP BUSY for data-port bytes.
module vdp_io_cycle
    import vdp_pkg::*;
#(
    parameter logic [7:0]  DATA_PORT     = VDP_DATA_PORT,
    parameter int unsigned STROBE_CYC    = 1,
    parameter int unsigned HOLD_CYC      = 2,
    parameter int unsigned RECOVER_CYC   = 1,
    parameter bit          STALL_ON_BUSY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_start,
    input  logic       byte_is_read,
    input  logic [7:0] byte_addr,
    input  logic [7:0] byte_wdata,
    output logic       byte_idle,
    output logic       byte_done,
    input  logic       vdp_busy,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic [7:0] io_addr,
    output logic [7:0] io_wdata,
    input  logic [7:0] io_rdata,
    output logic       iorq_l,
    output logic       rd_l,
    output logic       wr_l
);

    localparam logic [7:0] STROBE_LAST  = 8'(STROBE_CYC - 1);
    localparam logic [7:0] HOLD_LAST    = 8'(HOLD_CYC - 1);
    localparam logic [7:0] RECOVER_LAST = 8'(RECOVER_CYC - 1);

    bus_state_t state, state_n;
    logic [7:0] cnt;
    logic       is_read;
    logic       load;

    always_comb begin
        state_n   = state;
        byte_done = 1'b0;
        rsp_valid = 1'b0;
        load      = 1'b0;
        case (state)
            BUS_IDLE: begin
                if (byte_start) begin
                    state_n = BUS_SETUP;
                    load    = 1'b1;
                end
            end
            BUS_SETUP: begin
                if (!(STALL_ON_BUSY && io_addr == DATA_PORT && vdp_busy))
                    state_n = BUS_STROBE;
            end
            BUS_STROBE: begin
                if (cnt == STROBE_LAST)
                    state_n = (HOLD_CYC == 0) ? BUS_RECOVER : BUS_HOLD;
            end
            BUS_HOLD: begin
                if (cnt == HOLD_LAST)
                    state_n = BUS_RECOVER;
            end
            BUS_RECOVER: begin
                rsp_valid = is_read && (cnt == '0);
                if (cnt == RECOVER_LAST) begin
                    byte_done = 1'b1;
                    // A follow-on byte goes straight back to SETUP without an IDLE cycle
                    if (byte_start) begin
                        state_n = BUS_SETUP;
                        load    = 1'b1;
                    end else begin
                        state_n = BUS_IDLE;
                    end
                end
            end
            default: state_n = BUS_IDLE;
        endcase
    end

    assign byte_idle = (state == BUS_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BUS_IDLE;
            cnt      <= '0;
            is_read  <= 1'b0;
            io_addr  <= '0;
            io_wdata <= '0;
            rsp_data <= '0;
            iorq_l   <= 1'b1;
            rd_l     <= 1'b1;
            wr_l     <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state) ? '0 : cnt + 8'd1;
            if (load) begin
                io_addr  <= byte_addr;
                io_wdata <= byte_wdata;
                is_read  <= byte_is_read;
            end
            if (is_read && state != BUS_RECOVER && state_n == BUS_RECOVER)
                rsp_data <= io_rdata;
            iorq_l <= (state_n != BUS_STROBE);
            rd_l   <= !(state_n == BUS_STROBE && is_read);
            wr_l   <= !(state_n == BUS_STROBE && !is_read);
        end
    end

endmodule

// File: rtl/vdp_bus_master.sv
// VDP command front end: registers a command, splits it into one or two
// byte cycles on the data/control ports and reports completion.
module vdp_bus_master
    import vdp_pkg::*;
#(
    parameter logic [7:0]  DATA_PORT     = VDP_DATA_PORT,
    parameter logic [7:0]  CTRL_PORT     = VDP_CTRL_PORT,
    parameter int unsigned STROBE_CYC    = 1,
    parameter int unsigned HOLD_CYC      = 2,
    parameter int unsigned RECOVER_CYC   = 1,
    parameter bit          STALL_ON_BUSY = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  vdp_op_t     cmd_op,
    input  logic [7:0]  cmd_data,
    input  logic [15:0] cmd_arg,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        done,
    input  logic        vdp_busy,
    output logic [7:0]  io_addr,
    output logic [7:0]  io_wdata,
    input  logic [7:0]  io_rdata,
    output logic        IORQ_L,
    output logic        RD_L,
    output logic        WR_L
);

    seq_state_t  seq, seq_n;
    vdp_op_t     op_q;
    logic [7:0]  data_q;
    logic [15:0] arg_q;
    logic        accept;
    logic        byte_start, byte_is_read, byte_idle, byte_done;
    logic [7:0]  byte_addr, byte_wdata;

    assign cmd_ready = (seq == SEQ_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        seq_n      = seq;
        byte_start = 1'b0;
        done       = 1'b0;
        case (seq)
            SEQ_IDLE: begin
                if (accept)
                    seq_n = (cmd_op == OP_RSVD6 || cmd_op == OP_RSVD7) ? SEQ_NOP : SEQ_FIRST;
            end
            SEQ_FIRST: begin
                if (byte_idle)
                    byte_start = 1'b1;
                if (byte_done) begin
                    if (is_two_byte(op_q)) begin
                        byte_start = 1'b1;
                        seq_n      = SEQ_SECOND;
                    end else begin
                        done  = 1'b1;
                        seq_n = SEQ_IDLE;
                    end
                end
            end
            SEQ_SECOND: begin
                if (byte_done) begin
                    done  = 1'b1;
                    seq_n = SEQ_IDLE;
                end
            end
            SEQ_NOP:      seq_n = SEQ_NOP_DONE;
            SEQ_NOP_DONE: begin
                done  = 1'b1;
                seq_n = SEQ_IDLE;
            end
            default: seq_n = SEQ_IDLE;
        endcase
    end

    // byte_start coincides with byte_done only when launching the second byte
    always_comb begin
        byte_addr    = CTRL_PORT;
        byte_wdata   = data_q;
        byte_is_read = 1'b0;
        case (op_q)
            OP_WR_DATA:  byte_addr = DATA_PORT;
            OP_RD_DATA: begin
                byte_addr    = DATA_PORT;
                byte_is_read = 1'b1;
            end
            OP_RD_STAT:  byte_is_read = 1'b1;
            OP_SET_ADDR: byte_wdata = byte_done ? arg_q[15:8] : arg_q[7:0];
            OP_SET_REG:  if (byte_done) byte_wdata = VDP_REG_WRITE_CODE | {4'b0, arg_q[3:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq    <= SEQ_IDLE;
            op_q   <= OP_WR_DATA;
            data_q <= '0;
            arg_q  <= '0;
        end else begin
            seq <= seq_n;
            if (accept) begin
                op_q   <= cmd_op;
                data_q <= cmd_data;
                arg_q  <= cmd_arg;
            end
        end
    end

    vdp_io_cycle #(
        .DATA_PORT    (DATA_PORT),
        .STROBE_CYC   (STROBE_CYC),
        .HOLD_CYC     (HOLD_CYC),
        .RECOVER_CYC  (RECOVER_CYC),
        .STALL_ON_BUSY(STALL_ON_BUSY)
    ) u_cycle (
        .clk         (clk),
        .rst         (rst),
        .byte_start  (byte_start),
        .byte_is_read(byte_is_read),
        .byte_addr   (byte_addr),
        .byte_wdata  (byte_wdata),
        .byte_idle   (byte_idle),
        .byte_done   (byte_done),
        .vdp_busy    (vdp_busy),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .io_addr     (io_addr),
        .io_wdata    (io_wdata),
        .io_rdata    (io_rdata),
        .iorq_l      (IORQ_L),
        .rd_l        (RD_L),
        .wr_l        (WR_L)
    );

endmodule

// File: tb/tb_vdp_bus_master.sv
// Directed bench for vdp_bus_master: per-command cycle traces relative to the
// acceptance edge, checked against hand-computed timing and byte values.
module tb_vdp_bus_master;
    import vdp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    vdp_op_t     cmd_op;
    logic [7:0]  cmd_data;
    logic [15:0] cmd_arg;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        done;
    logic        vdp_busy;
    logic [7:0]  io_addr;
    logic [7:0]  io_wdata;
    logic [7:0]  io_rdata;
    logic        IORQ_L, RD_L, WR_L;

    int n_vec  = 0;
    int n_miss = 0;

    logic       iorq_tr [40];
    logic       rd_tr   [40];
    logic       wr_tr   [40];
    logic       done_tr [40];
    logic       rsp_tr  [40];
    logic       ready_tr[40];
    logic [7:0] addr_tr [40];
    logic [7:0] wdata_tr[40];
    logic [7:0] rspd_tr [40];
    int n_iorq, n_rd, n_wr, n_done, n_rsp;

    vdp_bus_master dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .cmd_arg  (cmd_arg),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .done     (done),
        .vdp_busy (vdp_busy),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .IORQ_L   (IORQ_L),
        .RD_L     (RD_L),
        .WR_L     (WR_L)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Trace index k is the cycle following edge E+k, E being the acceptance edge.
    task automatic run_cmd(input vdp_op_t op, input logic [7:0] d, input logic [15:0] a,
                           input int n, input int drop_k, input int rst_k,
                           input int hold_k, input logic [7:0] d2);
        int w = 0;
        while (!cmd_ready && w < 50) begin
            tick();
            w++;
        end
        chk("ready_wait", 16'(cmd_ready), 16'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_arg   = a;
        tick();
        n_iorq = 0; n_rd = 0; n_wr = 0; n_done = 0; n_rsp = 0;
        for (int k = 0; k < n; k++) begin
            if (k == 0) begin
                if (hold_k < 0) cmd_valid = 1'b0;
                cmd_data = d2;
                cmd_arg  = ~a;
            end
            if (k == hold_k) cmd_valid = 1'b0;
            if (k == drop_k) vdp_busy = 1'b0;
            if (k == rst_k) rst = 1'b1;
            if (rst_k >= 0 && k == rst_k + 1) rst = 1'b0;
            #1;
            iorq_tr[k]  = IORQ_L;
            rd_tr[k]    = RD_L;
            wr_tr[k]    = WR_L;
            done_tr[k]  = done;
            rsp_tr[k]   = rsp_valid;
            ready_tr[k] = cmd_ready;
            addr_tr[k]  = io_addr;
            wdata_tr[k] = io_wdata;
            rspd_tr[k]  = rsp_data;
            if (!IORQ_L)   n_iorq++;
            if (!RD_L)     n_rd++;
            if (!WR_L)     n_wr++;
            if (done)      n_done++;
            if (rsp_valid) n_rsp++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int first_lo, second_lo;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_WR_DATA;
        cmd_data  = '0;
        cmd_arg   = '0;
        vdp_busy  = 1'b0;
        io_rdata  = 8'h80;
        repeat (3) tick();
        chk("rst_iorq",  16'(IORQ_L),    16'd1);
        chk("rst_rd",    16'(RD_L),      16'd1);
        chk("rst_wr",    16'(WR_L),      16'd1);
        chk("rst_addr",  16'(io_addr),   16'h00);
        chk("rst_wdata", 16'(io_wdata),  16'h00);
        chk("rst_rsp",   16'(rsp_valid), 16'd0);
        chk("rst_rspd",  16'(rsp_data),  16'h00);
        chk("rst_done",  16'(done),      16'd0);
        chk("rst_ready", 16'(cmd_ready), 16'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 16'(cmd_ready), 16'd1);

        // WR_DATA 0x5A
        run_cmd(OP_WR_DATA, 8'h5A, 16'h0000, 8, -1, -1, -1, 8'hA5);
        chk("wd_iorq_n",  16'(n_iorq),     16'd1);
        chk("wd_iorq_k2", 16'(iorq_tr[2]), 16'd0);
        chk("wd_wr_n",    16'(n_wr),       16'd1);
        chk("wd_wr_k2",   16'(wr_tr[2]),   16'd0);
        chk("wd_rd_n",    16'(n_rd),       16'd0);
        chk("wd_addr",    16'(addr_tr[2]), 16'h00BE);
        for (int k = 1; k <= 5; k++)
            chk("wd_wdata_stable", 16'(wdata_tr[k]), 16'h005A);
        chk("wd_done_n",  16'(n_done),      16'd1);
        chk("wd_done_k5", 16'(done_tr[5]),  16'd1);
        chk("wd_ready_k5", 16'(ready_tr[5]), 16'd0);
        chk("wd_ready_k6", 16'(ready_tr[6]), 16'd1);

        // SET_ADDR code=01 addr=0x1234 -> 0x34 then 0x52 to control port
        run_cmd(OP_SET_ADDR, 8'h00, {2'b01, 14'h1234}, 12, -1, -1, -1, 8'hFF);
        chk("sa_iorq_n",   16'(n_iorq),      16'd2);
        chk("sa_wr_n",     16'(n_wr),        16'd2);
        chk("sa_iorq_k2",  16'(iorq_tr[2]),  16'd0);
        chk("sa_iorq_k7",  16'(iorq_tr[7]),  16'd0);
        chk("sa_byte0",    16'(wdata_tr[2]), 16'h0034);
        chk("sa_byte1",    16'(wdata_tr[7]), 16'h0052);
        chk("sa_addr0",    16'(addr_tr[2]),  16'h00BF);
        chk("sa_addr1",    16'(addr_tr[7]),  16'h00BF);
        chk("sa_done_n",   16'(n_done),      16'd1);
        chk("sa_done_k10", 16'(done_tr[10]), 16'd1);

        // RD_STAT with status 0x80
        io_rdata = 8'h80;
        run_cmd(OP_RD_STAT, 8'h00, 16'h0000, 8, -1, -1, -1, 8'hFF);
        chk("rs_rd_n",    16'(n_rd),        16'd1);
        chk("rs_rd_k2",   16'(rd_tr[2]),    16'd0);
        chk("rs_wr_n",    16'(n_wr),        16'd0);
        chk("rs_addr",    16'(addr_tr[2]),  16'h00BF);
        chk("rs_rsp_n",   16'(n_rsp),       16'd1);
        chk("rs_rsp_k5",  16'(rsp_tr[5]),   16'd1);
        chk("rs_rspd_k5", 16'(rspd_tr[5]),  16'h0080);
        chk("rs_done_k5", 16'(done_tr[5]),  16'd1);

        // RD_DATA with 0xC3 on the data port
        io_rdata = 8'hC3;
        run_cmd(OP_RD_DATA, 8'h00, 16'h0000, 8, -1, -1, -1, 8'hFF);
        chk("rdd_addr",    16'(addr_tr[2]), 16'h00BE);
        chk("rdd_rd_k2",   16'(rd_tr[2]),   16'd0);
        chk("rdd_rspd_k5", 16'(rspd_tr[5]), 16'h00C3);
        chk("rdd_rsp_k5",  16'(rsp_tr[5]),  16'd1);

        // Busy stall on data port, released at k=20
        vdp_busy = 1'b1;
        run_cmd(OP_WR_DATA, 8'h33, 16'h0000, 28, 20, -1, -1, 8'hCC);
        chk("st_iorq_k20", 16'(iorq_tr[20]), 16'd1);
        chk("st_iorq_k21", 16'(iorq_tr[21]), 16'd0);
        chk("st_iorq_n",   16'(n_iorq),      16'd1);
        chk("st_wdata",    16'(wdata_tr[21]), 16'h0033);
        chk("st_done_k24", 16'(done_tr[24]), 16'd1);

        // Control-port write ignores busy
        vdp_busy = 1'b1;
        run_cmd(OP_WR_CTRL, 8'h44, 16'h0000, 8, -1, -1, -1, 8'hBB);
        chk("wc_iorq_k2", 16'(iorq_tr[2]), 16'd0);
        chk("wc_addr",    16'(addr_tr[2]), 16'h00BF);
        chk("wc_wdata",   16'(wdata_tr[2]), 16'h0044);
        chk("wc_done_k5", 16'(done_tr[5]), 16'd1);
        vdp_busy = 1'b0;

        // Reset asserted during the first strobe of SET_REG
        run_cmd(OP_SET_REG, 8'h12, 16'h0007, 10, -1, 2, -1, 8'hED);
        chk("rr_iorq_k2",  16'(iorq_tr[2]),  16'd0);
        chk("rr_iorq_k3",  16'(iorq_tr[3]),  16'd1);
        chk("rr_wr_k3",    16'(wr_tr[3]),    16'd1);
        chk("rr_ready_k2", 16'(ready_tr[2]), 16'd0);
        chk("rr_ready_k3", 16'(ready_tr[3]), 16'd1);
        chk("rr_iorq_n",   16'(n_iorq),      16'd1);
        chk("rr_done_n",   16'(n_done),      16'd0);
        chk("rr_rsp_n",    16'(n_rsp),       16'd0);

        // SET_REG after reset runs normally: 0x12 then 0x87
        run_cmd(OP_SET_REG, 8'h12, 16'h0007, 12, -1, -1, -1, 8'hED);
        chk("sr_byte0",    16'(wdata_tr[2]), 16'h0012);
        chk("sr_byte1",    16'(wdata_tr[7]), 16'h0087);
        chk("sr_addr",     16'(addr_tr[7]),  16'h00BF);
        chk("sr_iorq_n",   16'(n_iorq),      16'd2);
        chk("sr_done_k10", 16'(done_tr[10]), 16'd1);

        // Back-to-back WR_DATA with cmd_valid held; data changes after first accept
        run_cmd(OP_WR_DATA, 8'h01, 16'h0000, 14, -1, -1, 7, 8'h02);
        first_lo = -1;
        second_lo = -1;
        for (int k = 0; k < 14; k++) begin
            if (!iorq_tr[k]) begin
                if (first_lo < 0) first_lo = k;
                else if (second_lo < 0) second_lo = k;
            end
        end
        chk("bb_iorq_n",   16'(n_iorq),       16'd2);
        chk("bb_first",    16'(first_lo),     16'd2);
        chk("bb_second",   16'(second_lo),    16'd9);
        chk("bb_gap_ge2",  16'(second_lo - first_lo - 1 >= 2), 16'd1);
        chk("bb_wdata0",   16'(wdata_tr[2]),  16'h0001);
        chk("bb_wdata1",   16'(wdata_tr[9]),  16'h0002);
        chk("bb_done_n",   16'(n_done),       16'd2);
        chk("bb_done_k5",  16'(done_tr[5]),   16'd1);
        chk("bb_done_k12", 16'(done_tr[12]),  16'd1);

        // Reserved op 7: done one cycle after acceptance, no bus activity
        run_cmd(OP_RSVD7, 8'h00, 16'h0000, 4, -1, -1, -1, 8'hFF);
        chk("n7_done_k0",  16'(done_tr[0]),  16'd0);
        chk("n7_done_k1",  16'(done_tr[1]),  16'd1);
        chk("n7_done_n",   16'(n_done),      16'd1);
        chk("n7_iorq_n",   16'(n_iorq),      16'd0);
        chk("n7_ready_k1", 16'(ready_tr[1]), 16'd0);
        chk("n7_ready_k2", 16'(ready_tr[2]), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
